// File: rtl/imem_uart_loader.sv
// imem_uart_loader: receives a program over UART 8N1 and writes little-endian words into
// instruction memory at 0,4,8,..., holding the CPU in reset while a load frame is in flight.
module imem_uart_loader #(
  parameter int         CLK_FREQ   = 50_000_000,
  parameter int         BAUD       = 115200,
  parameter int         IMEM_WORDS = 256,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        uart_rx,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_err,
  output logic [15:0] words_loaded
);
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] MAX_WORDS = 16'(IMEM_WORDS);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [2:0] {P_IDLE, P_LEN_LO, P_LEN_HI, P_DATA, P_DONE} p_state_t;

  rx_state_t        rx_state_q, rx_state_d;
  logic             rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             byte_valid, frame_err;
  logic [7:0]       rx_byte;

  p_state_t    p_state_q, p_state_d;
  logic [15:0] len_q, len_d, words_q, words_d, len_full;
  logic [23:0] word_q, word_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic        hold_q, hold_d, done_q, done_d, err_q, err_d, we_q, we_d, last_word;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      bit_idx_q  <= '0;
      rx_shift_q <= '0;
      p_state_q  <= P_IDLE;
      len_q      <= '0;
      word_q     <= '0;
      byte_idx_q <= '0;
      words_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      bit_idx_q  <= bit_idx_d;
      rx_shift_q <= rx_shift_d;
      p_state_q  <= p_state_d;
      len_q      <= len_d;
      word_q     <= word_d;
      byte_idx_q <= byte_idx_d;
      words_q    <= words_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  // Start bit is re-checked at mid-bit so short low glitches fall back to idle silently.
  always_comb begin
    rx_meta_d  = uart_rx;
    rx_sync_d  = rx_meta_q;
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(1);
    bit_idx_d  = bit_idx_q;
    rx_shift_d = rx_shift_q;
    unique case (rx_state_q)
      RX_IDLE: begin
        rx_cnt_d = '0;
        if (!rx_sync_q) rx_state_d = RX_START;
      end
      RX_START: if (rx_cnt_q == HALF_LAST) begin
        rx_cnt_d   = '0;
        bit_idx_d  = '0;
        rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
      end
      RX_DATA: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
        bit_idx_d  = bit_idx_q + 3'd1;
        if (bit_idx_q == 3'd7) rx_state_d = RX_STOP;
      end
      RX_STOP: if (rx_cnt_q == BIT_LAST) begin
        rx_cnt_d   = '0;
        rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    if (rx_state_q == RX_STOP && rx_cnt_q == BIT_LAST) begin
      byte_valid = rx_sync_q;
      frame_err  = !rx_sync_q;
    end
  end

  assign rx_byte   = rx_shift_q;
  assign len_full  = {rx_byte, len_q[7:0]};
  assign last_word = (words_q + 16'd1) == len_q;

  always_comb begin
    p_state_d = p_state_q;
    unique case (p_state_q)
      P_IDLE:   if (byte_valid && rx_byte == SYNC_BYTE) p_state_d = P_LEN_LO;
      P_LEN_LO: if (frame_err) p_state_d = P_IDLE;
                else if (byte_valid) p_state_d = P_LEN_HI;
      P_LEN_HI: if (frame_err) p_state_d = P_IDLE;
                else if (byte_valid)
                  p_state_d = (len_full == '0 || len_full > MAX_WORDS) ? P_IDLE : P_DATA;
      P_DATA:   if (frame_err) p_state_d = P_IDLE;
                else if (byte_valid && byte_idx_q == 2'd3 && last_word) p_state_d = P_DONE;
      P_DONE:   p_state_d = P_IDLE;
      default:  p_state_d = P_IDLE;
    endcase
  end

  // The final write and load_done land together; P_DONE releases cpu_hold one cycle later.
  always_comb begin
    len_d      = len_q;
    word_d     = word_q;
    byte_idx_d = byte_idx_q;
    words_d    = words_q;
    hold_d     = hold_q;
    done_d     = done_q;
    err_d      = err_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    unique case (p_state_q)
      P_IDLE: if (byte_valid && rx_byte == SYNC_BYTE) begin
        done_d  = 1'b0;
        err_d   = 1'b0;
        words_d = '0;
        hold_d  = 1'b1;
      end
      P_LEN_LO: if (frame_err) begin
        err_d  = 1'b1;
        hold_d = 1'b0;
      end else if (byte_valid) begin
        len_d[7:0] = rx_byte;
      end
      P_LEN_HI: if (frame_err) begin
        err_d  = 1'b1;
        hold_d = 1'b0;
      end else if (byte_valid) begin
        len_d      = len_full;
        byte_idx_d = '0;
        if (len_full == '0) begin
          done_d = 1'b1;
          hold_d = 1'b0;
        end else if (len_full > MAX_WORDS) begin
          err_d  = 1'b1;
          hold_d = 1'b0;
        end
      end
      P_DATA: if (frame_err) begin
        err_d  = 1'b1;
        hold_d = 1'b0;
      end else if (byte_valid) begin
        byte_idx_d = byte_idx_q + 2'd1;
        case (byte_idx_q)
          2'd0: word_d[7:0]   = rx_byte;
          2'd1: word_d[15:8]  = rx_byte;
          2'd2: word_d[23:16] = rx_byte;
          default: begin
            we_d    = 1'b1;
            addr_d  = {14'd0, words_q, 2'b00};
            wdata_d = {rx_byte, word_q};
            words_d = words_q + 16'd1;
            if (last_word) done_d = 1'b1;
          end
        endcase
      end
      P_DONE:  hold_d = 1'b0;
      default: ;
    endcase
  end

  assign imem_we      = we_q;
  assign imem_addr    = addr_q;
  assign imem_wdata   = wdata_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign words_loaded = words_q;
endmodule

// File: tb/tb_imem_uart_loader.sv
// Bench for imem_uart_loader: UART frames driven at a fast bit rate, writes checked through a
// scoreboard fed by a frame-level reference model, sticky flags checked after each frame.
module tb_imem_uart_loader;
  localparam int         CLK_FREQ   = 1_600_000;
  localparam int         BAUD       = 100_000;
  localparam int         IMEM_WORDS = 256;
  localparam logic [7:0] SYNC       = 8'hA5;
  localparam int         CPB        = CLK_FREQ / BAUD;

  typedef logic [7:0] byteQ_t[$];
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk, reset, uartRx;
  logic        imemWe, cpuHold, loadDone, loadErr;
  logic [31:0] imemAddr, imemWdata;
  logic [15:0] wordsLoaded;

  int testsRun = 0;
  int testsFailed = 0;

  wr_t         expQ[$];
  logic        expDone, expErr, expHold;
  logic [15:0] expWords;
  logic [31:0] expLastAddr, expLastData;

  byteQ_t      frame;
  int          nw, badIdx, dataStart;
  logic [7:0]  junk;

  imem_uart_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .IMEM_WORDS(IMEM_WORDS), .SYNC_BYTE(SYNC)
  ) dut (
    .clk(clk), .reset(reset), .uart_rx(uartRx),
    .imem_we(imemWe), .imem_addr(imemAddr), .imem_wdata(imemWdata),
    .cpu_hold(cpuHold), .load_done(loadDone), .load_err(loadErr),
    .words_loaded(wordsLoaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: locate the sync byte, decode the length and slice whole words.
  task automatic modelFrame(input byteQ_t bytes, input int bad);
    int stop, s, len, nWords, b;
    wr_t w;
    stop = (bad >= 0) ? bad : bytes.size();
    s = -1;
    for (int i = 0; i < stop; i++)
      if (s < 0 && bytes[i] == SYNC) s = i;
    if (s < 0) return;
    expDone = 1'b0; expErr = 1'b0; expWords = '0; expHold = 1'b1;
    if (s + 2 >= stop) begin
      if (stop < bytes.size()) begin expErr = 1'b1; expHold = 1'b0; end
      return;
    end
    len = int'(bytes[s+1]) + 256 * int'(bytes[s+2]);
    if (len == 0) begin expDone = 1'b1; expHold = 1'b0; return; end
    if (len > IMEM_WORDS) begin expErr = 1'b1; expHold = 1'b0; return; end
    nWords = (stop - (s + 3)) / 4;
    if (nWords > len) nWords = len;
    for (int k = 0; k < nWords; k++) begin
      b = s + 3 + 4 * k;
      w.addr = 32'(4 * k);
      w.data = {bytes[b+3], bytes[b+2], bytes[b+1], bytes[b]};
      expQ.push_back(w);
      expLastAddr = w.addr;
      expLastData = w.data;
    end
    expWords = 16'(nWords);
    if (nWords == len) begin expDone = 1'b1; expHold = 1'b0; end
    else if (stop < bytes.size()) begin expErr = 1'b1; expHold = 1'b0; end
  endtask

  task automatic sendByte(input logic [7:0] b, input logic stopBit);
    uartRx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uartRx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uartRx = stopBit;
    repeat (CPB) @(negedge clk);
    uartRx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input byteQ_t bytes, input int bad);
    int last;
    modelFrame(bytes, bad);
    last = (bad >= 0) ? bad : bytes.size() - 1;
    for (int i = 0; i <= last; i++) sendByte(bytes[i], i != bad);
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_done"}, 32'(loadDone), 32'(expDone));
    checkValue({tag, "_err"}, 32'(loadErr), 32'(expErr));
    checkValue({tag, "_hold"}, 32'(cpuHold), 32'(expHold));
    checkValue({tag, "_words"}, 32'(wordsLoaded), 32'(expWords));
    checkValue({tag, "_addr"}, imemAddr, expLastAddr);
    checkValue({tag, "_wdata"}, imemWdata, expLastData);
  endtask

  task automatic checkReset(input string tag);
    expDone = 1'b0; expErr = 1'b0; expHold = 1'b0; expWords = '0;
    expLastAddr = '0; expLastData = '0;
    checkValue({tag, "_we"}, 32'(imemWe), 32'd0);
    checkOutput(tag);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (imemWe === 1'b1) begin
        testsRun++;
        if (expQ.size() == 0) begin
          testsFailed++;
          $display("[TB] FAIL write_unexpected: got addr=%h data=%h, expected no write", imemAddr, imemWdata);
        end else begin
          w = expQ.pop_front();
          if (imemAddr !== w.addr || imemWdata !== w.data) begin
            testsFailed++;
            $display("[TB] FAIL write: got addr=%h data=%h, expected addr=%h data=%h",
                     imemAddr, imemWdata, w.addr, w.data);
          end
        end
      end
    end
  end

  initial begin
    uartRx = 1'b1;
    reset  = 1'b1;
    repeat (4) @(negedge clk);
    checkReset("reset");
    reset = 1'b0;
    repeat (10) @(negedge clk);

    frame = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    applyStimulus(frame, -1);
    checkOutput("two_words");
    checkValue("two_words_last_data", imemWdata, 32'h0020_0593);

    uartRx = 1'b0;
    repeat (3) @(negedge clk);
    uartRx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    checkOutput("glitch");

    frame = {8'hA5, 8'h01, 8'h00, 8'h37};
    applyStimulus(frame, 3);
    checkOutput("bad_stop");
    frame = {8'hA5, 8'h00, 8'h00};
    applyStimulus(frame, -1);
    checkOutput("zero_len");

    frame = {8'hA5, 8'h01, 8'h01};
    applyStimulus(frame, -1);
    checkOutput("too_long");

    frame = {8'hA5, 8'h04, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    applyStimulus(frame, -1);
    checkOutput("mid_frame");
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkReset("mid_reset");
    checkValue("mid_reset_pending", 32'(expQ.size()), 32'd0);
    repeat (2 * CPB) @(negedge clk);
    frame = {8'hA5, 8'h04, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08,
             8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h10};
    applyStimulus(frame, -1);
    checkOutput("after_reset");

    frame = {8'h00, 8'hFF, 8'h13, 8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    applyStimulus(frame, -1);
    checkOutput("leading_junk");
    checkValue("leading_junk_data", imemWdata, 32'hDEAD_BEEF);

    for (int f = 0; f < 6; f++) begin
      frame.delete();
      if ($urandom_range(0, 1) == 1) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = 8'h00;
        frame.push_back(junk);
      end
      nw = $urandom_range(1, 5);
      frame.push_back(SYNC);
      frame.push_back(8'(nw));
      frame.push_back(8'h00);
      dataStart = frame.size();
      for (int i = 0; i < 4 * nw; i++) frame.push_back(8'($urandom));
      if (f == 0) frame[dataStart] = SYNC;
      badIdx = -1;
      if (f % 3 == 2) badIdx = $urandom_range(dataStart, frame.size() - 1);
      applyStimulus(frame, badIdx);
      checkOutput("random");
    end

    checkValue("writes_outstanding", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
